// File: rtl/tisc_spi_pkg.sv
// Shared types and constants for the TISC SPI flash command sequencer.
// States WIPTX/WIPPOLL/WIPRX exist only when TISC_SPI_WIP_POLL_EN is defined.
package tisc_spi_pkg;

  typedef enum logic [3:0] {
    ST_INIT, ST_IDLE, ST_CSON, ST_TX, ST_POLL, ST_RX, ST_RDHOLD, ST_CSOFF, ST_DONE
`ifdef TISC_SPI_WIP_POLL_EN
    , ST_WIPTX, ST_WIPPOLL, ST_WIPRX
`endif
  } state_e;

  localparam logic [1:0] ADR_SPCR = 2'd0;
  localparam logic [1:0] ADR_SPSR = 2'd1;
  localparam logic [1:0] ADR_SPDR = 2'd2;
  localparam logic [1:0] ADR_SPER = 2'd3;

  localparam int SPCR_SPE  = 6;
  localparam int SPCR_MSTR = 4;
  localparam int SPCR_CPOL = 3;
  localparam int SPCR_CPHA = 2;

  localparam int SPSR_RFEMPTY = 0;
  localparam int SPSR_SPIF    = 7;

  localparam logic [7:0] OP_RDSR    = 8'h05;
  localparam logic [7:0] DUMMY_BYTE = 8'hFF;

  // Mode 0 master, core enabled, clock divider in SPR.
  function automatic logic [7:0] spcr_init(input logic [1:0] spr);
    logic [7:0] v;
    v = '0;
    v[SPCR_SPE]  = 1'b1;
    v[SPCR_MSTR] = 1'b1;
    v[1:0]       = spr;
    return v;
  endfunction

endpackage

// File: rtl/tisc_spi_wb_access.sv
// Single classic-cycle WISHBONE access engine with ack timeout.
// done/rdata/timeout are valid combinationally in the ack (or expiry) cycle.
module tisc_spi_wb_access #(
  parameter int TMO_W = 8
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       go,
  input  logic       we,
  input  logic [1:0] adr,
  input  logic [7:0] dat,
  output logic       done,
  output logic [7:0] rdata,
  output logic       timeout,
  output logic       spi_cyc_o,
  output logic       spi_stb_o,
  output logic       spi_we_o,
  output logic [1:0] spi_adr_o,
  output logic [7:0] spi_dat_o,
  input  logic [7:0] spi_dat_i,
  input  logic       spi_ack_i
);

  logic             cyc_q;
  logic [TMO_W-1:0] tmo_cnt;

  assign spi_cyc_o = cyc_q;
  assign spi_stb_o = cyc_q;
  assign done      = cyc_q & spi_ack_i;
  assign timeout   = cyc_q & ~spi_ack_i & (&tmo_cnt);
  assign rdata     = spi_dat_i;

  // Address/data/we are captured at go so they stay put for the whole access.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cyc_q     <= 1'b0;
      tmo_cnt   <= '0;
      spi_we_o  <= 1'b0;
      spi_adr_o <= '0;
      spi_dat_o <= '0;
    end else if (!cyc_q) begin
      if (go) begin
        cyc_q     <= 1'b1;
        tmo_cnt   <= '0;
        spi_we_o  <= we;
        spi_adr_o <= adr;
        spi_dat_o <= dat;
      end
    end else if (spi_ack_i || (&tmo_cnt)) begin
      cyc_q <= 1'b0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tisc_spi_flash_seq.sv
// Flash command sequencer driving simple_spi_top over WISHBONE and owning CS.
// Define TISC_SPI_WIP_POLL_EN to poll RDSR until WIP clears after write commands.
module tisc_spi_flash_seq
  import tisc_spi_pkg::*;
#(
  parameter logic [1:0] CLKDIV = 2'b00,
  parameter int         LEN_W  = 16,
  parameter int         TMO_W  = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [7:0]       cmd_opcode_i,
  input  logic [23:0]      cmd_addr_i,
  input  logic             cmd_has_addr_i,
  input  logic             cmd_write_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic [7:0]       wr_data_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  output logic [7:0]       rd_data_o,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             spi_cyc_o,
  output logic             spi_stb_o,
  output logic             spi_we_o,
  output logic [1:0]       spi_adr_o,
  output logic [7:0]       spi_dat_o,
  input  logic [7:0]       spi_dat_i,
  input  logic             spi_ack_i,
  output logic             spi_cs_o
);

  localparam int IW = LEN_W + 1;

  state_e           state, state_nxt;
  logic             acc_pend, init_done, err_q, cs_q, cs_nxt, wr_q;
  logic [7:0]       op_q, rd_q, tx_byte;
  logic [23:0]      addr_q;
  logic [LEN_W-1:0] len_q;
  logic [2:0]       hdr_q;
  logic [IW-1:0]    idx_q;
  logic             go, g_we;
  logic [1:0]       g_adr;
  logic [7:0]       g_dat, acc_rdata;
  logic             acc_done, acc_tmo;
  logic             accept, data_ph, last, rd_byte, adv;
`ifdef TISC_SPI_WIP_POLL_EN
  logic             widx_q, wip_q;
`endif

  assign accept  = (state == ST_IDLE) && init_done && cmd_valid_i;
  assign data_ph = idx_q >= IW'(hdr_q);
  assign last    = (idx_q + IW'(1)) == (IW'(hdr_q) + IW'(len_q));
  assign rd_byte = data_ph && !wr_q;
  assign adv     = ((state == ST_RX) && acc_done && !rd_byte) ||
                   ((state == ST_RDHOLD) && rd_ready_i);

  assign cmd_ready_o = (state == ST_IDLE) && init_done;
  assign busy_o      = (state != ST_IDLE) && (state != ST_INIT);
  assign done_o      = (state == ST_DONE);
  assign rd_valid_o  = (state == ST_RDHOLD);
  assign wr_ready_o  = (state == ST_TX) && data_ph && wr_q && acc_done;
  assign rd_data_o   = rd_q;
  assign err_o       = err_q;
  assign spi_cs_o    = cs_q;

  always_comb begin
    tx_byte = DUMMY_BYTE;
    if (!data_ph) begin
      case (idx_q[1:0])
        2'd0:    tx_byte = op_q;
        2'd1:    tx_byte = addr_q[23:16];
        2'd2:    tx_byte = addr_q[15:8];
        default: tx_byte = addr_q[7:0];
      endcase
    end else if (wr_q) begin
      tx_byte = wr_data_i;
    end
  end

  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    g_we      = 1'b0;
    g_adr     = ADR_SPCR;
    g_dat     = '0;
    case (state)
      ST_INIT: begin
        go    = !acc_pend;
        g_we  = 1'b1;
        g_dat = spcr_init(CLKDIV);
        if (acc_done) state_nxt = ST_IDLE;
      end
      ST_IDLE: if (accept) state_nxt = ST_CSON;
      ST_CSON: state_nxt = ST_TX;
      ST_TX: begin
        go    = !acc_pend && (!(data_ph && wr_q) || wr_valid_i);
        g_we  = 1'b1;
        g_adr = ADR_SPDR;
        g_dat = tx_byte;
        if (acc_done) state_nxt = ST_POLL;
      end
      ST_POLL: begin
        go    = !acc_pend;
        g_adr = ADR_SPSR;
        if (acc_done && !acc_rdata[SPSR_RFEMPTY]) state_nxt = ST_RX;
      end
      ST_RX: begin
        go    = !acc_pend;
        g_adr = ADR_SPDR;
        if (acc_done) state_nxt = rd_byte ? ST_RDHOLD : (last ? ST_CSOFF : ST_TX);
      end
      ST_RDHOLD: if (rd_ready_i) state_nxt = last ? ST_CSOFF : ST_TX;
      ST_CSOFF: begin
        state_nxt = ST_DONE;
`ifdef TISC_SPI_WIP_POLL_EN
        if (wr_q && wip_q && !err_q) state_nxt = ST_WIPTX;
`endif
      end
      ST_DONE: state_nxt = ST_IDLE;
`ifdef TISC_SPI_WIP_POLL_EN
      ST_WIPTX: begin
        go    = !acc_pend;
        g_we  = 1'b1;
        g_adr = ADR_SPDR;
        g_dat = widx_q ? DUMMY_BYTE : OP_RDSR;
        if (acc_done) state_nxt = ST_WIPPOLL;
      end
      ST_WIPPOLL: begin
        go    = !acc_pend;
        g_adr = ADR_SPSR;
        if (acc_done && !acc_rdata[SPSR_RFEMPTY]) state_nxt = ST_WIPRX;
      end
      ST_WIPRX: begin
        go    = !acc_pend;
        g_adr = ADR_SPDR;
        if (acc_done) state_nxt = widx_q ? ST_CSOFF : ST_WIPTX;
      end
`endif
      default: state_nxt = ST_INIT;
    endcase
    // INIT just retries; a stuck access elsewhere abandons the command.
    if (acc_tmo && (state != ST_INIT)) state_nxt = ST_CSOFF;
  end

  always_comb begin
    cs_nxt = 1'b0;
    case (state_nxt)
      ST_CSON, ST_TX, ST_POLL, ST_RX, ST_RDHOLD: cs_nxt = 1'b1;
`ifdef TISC_SPI_WIP_POLL_EN
      ST_WIPTX, ST_WIPPOLL, ST_WIPRX: cs_nxt = 1'b1;
`endif
      default: cs_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= ST_INIT;
      cs_q      <= 1'b0;
      acc_pend  <= 1'b0;
      init_done <= 1'b0;
      err_q     <= 1'b0;
      wr_q      <= 1'b0;
      op_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      hdr_q     <= '0;
      idx_q     <= '0;
      rd_q      <= '0;
`ifdef TISC_SPI_WIP_POLL_EN
      widx_q    <= 1'b0;
      wip_q     <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cs_q  <= cs_nxt;
      if (go) acc_pend <= 1'b1;
      else if (acc_done || acc_tmo) acc_pend <= 1'b0;
      if ((state == ST_INIT) && acc_done) init_done <= 1'b1;
      if (acc_tmo) err_q <= 1'b1;
      if (accept) begin
        op_q   <= cmd_opcode_i;
        addr_q <= cmd_addr_i;
        wr_q   <= cmd_write_i;
        len_q  <= cmd_len_i;
        hdr_q  <= cmd_has_addr_i ? 3'd4 : 3'd1;
        idx_q  <= '0;
        err_q  <= 1'b0;
`ifdef TISC_SPI_WIP_POLL_EN
        wip_q  <= 1'b1;
`endif
      end
      if (adv) idx_q <= idx_q + IW'(1);
      if ((state == ST_RX) && acc_done && rd_byte) rd_q <= acc_rdata;
`ifdef TISC_SPI_WIP_POLL_EN
      if (state == ST_CSOFF) widx_q <= 1'b0;
      if ((state == ST_WIPRX) && acc_done) begin
        if (!widx_q) widx_q <= 1'b1;
        else wip_q <= acc_rdata[0];
      end
`endif
    end
  end

  tisc_spi_wb_access #(.TMO_W(TMO_W)) u_acc (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .go        (go),
    .we        (g_we),
    .adr       (g_adr),
    .dat       (g_dat),
    .done      (acc_done),
    .rdata     (acc_rdata),
    .timeout   (acc_tmo),
    .spi_cyc_o (spi_cyc_o),
    .spi_stb_o (spi_stb_o),
    .spi_we_o  (spi_we_o),
    .spi_adr_o (spi_adr_o),
    .spi_dat_o (spi_dat_o),
    .spi_dat_i (spi_dat_i),
    .spi_ack_i (spi_ack_i)
  );

endmodule

// File: tb/tb_tisc_spi_flash_seq.sv
// Directed bench for tisc_spi_flash_seq with a behavioural simple_spi core model.
// Inputs driven #1 after posedge; DUT outputs sampled on negedge.
module tb_tisc_spi_flash_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_has_addr = 1'b0, cmd_write = 1'b0;
  logic [7:0]  cmd_opcode = '0;
  logic [23:0] cmd_addr = '0;
  logic [15:0] cmd_len = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_valid = 1'b0, rd_ready = 1'b1;
  logic        cmd_ready_o, wr_ready_o, rd_valid_o, busy_o, done_o, err_o;
  logic [7:0]  rd_data_o;
  logic        spi_cyc_o, spi_stb_o, spi_we_o, spi_ack_i, spi_cs_o;
  logic [1:0]  spi_adr_o;
  logic [7:0]  spi_dat_o, spi_dat_i;

  int checks = 0, errors = 0;

  // core model state
  logic [7:0] miso_q[$];
  logic [7:0] rx_byte = 8'h00;
  int         poll_cnt = 0, poll_delay = 0;
  logic       blk_spdr = 1'b0;

  // monitor state
  logic [7:0] tx_log[$], rd_log[$], spcr_log[$];
  int acc_cnt = 0, cs_hi_cnt = 0, cs_viol = 0, done_cnt = 0, wr_cnt = 0;
  int cyc_cnt = 0, cyc_run = 0, last_run = 0;

  always #5 clk = ~clk;

  tisc_spi_flash_seq dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o),
    .cmd_opcode_i(cmd_opcode), .cmd_addr_i(cmd_addr),
    .cmd_has_addr_i(cmd_has_addr), .cmd_write_i(cmd_write), .cmd_len_i(cmd_len),
    .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready_o),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .spi_cyc_o(spi_cyc_o), .spi_stb_o(spi_stb_o), .spi_we_o(spi_we_o),
    .spi_adr_o(spi_adr_o), .spi_dat_o(spi_dat_o), .spi_dat_i(spi_dat_i),
    .spi_ack_i(spi_ack_i), .spi_cs_o(spi_cs_o)
  );

  assign spi_ack_i = spi_cyc_o & spi_stb_o & ~(blk_spdr & spi_we_o & (spi_adr_o == 2'd2));
  assign spi_dat_i = (spi_adr_o == 2'd1) ? {7'b0, poll_cnt != 0} :
                     (spi_adr_o == 2'd2) ? rx_byte : 8'h00;

  always @(posedge clk) begin
    if (spi_cyc_o && spi_stb_o && spi_ack_i) begin
      if (spi_we_o && spi_adr_o == 2'd2) begin
        poll_cnt <= poll_delay;
        if (miso_q.size() > 0) begin
          rx_byte <= miso_q[0];
          void'(miso_q.pop_front());
        end else rx_byte <= 8'h00;
      end else if (!spi_we_o && spi_adr_o == 2'd1 && poll_cnt != 0) begin
        poll_cnt <= poll_cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (spi_cyc_o && spi_stb_o && spi_ack_i) begin
      acc_cnt++;
      if (spi_we_o && spi_adr_o == 2'd0) spcr_log.push_back(spi_dat_o);
      if (spi_we_o && spi_adr_o == 2'd2) tx_log.push_back(spi_dat_o);
      if (spi_adr_o != 2'd0 && !spi_cs_o) cs_viol++;
    end
    if (spi_cs_o) cs_hi_cnt++;
    if (rd_valid_o && rd_ready) rd_log.push_back(rd_data_o);
    if (done_o) done_cnt++;
    if (wr_ready_o) wr_cnt++;
    if (spi_cyc_o) begin cyc_run++; cyc_cnt++; end
    else if (cyc_run != 0) begin last_run = cyc_run; cyc_run = 0; end
  end

  task automatic send_cmd(input logic [7:0] op, input logic [23:0] a, input logic ha,
                          input logic w, input logic [15:0] len);
    int n;
    @(posedge clk); #1;
    cmd_opcode = op; cmd_addr = a; cmd_has_addr = ha; cmd_write = w; cmd_len = len;
    cmd_valid = 1'b1;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      if (cmd_ready_o) break;
      n++;
    end
    checks++;
    if (!cmd_ready_o) begin errors++; $display("FAIL cmd_accept: cmd_ready_o=0 required 1"); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit, output int lat);
    logic seen;
    seen = 1'b0; lat = 0;
    while (!seen && lat < limit) begin
      @(negedge clk);
      lat++;
      seen = done_o;
    end
    #1;
    checks++;
    if (!seen) begin errors++; $display("FAIL %s_done: done_o not seen within %0d cycles", name, limit); end
  endtask

  task automatic test_reset;
    int n;
    #12;
    checks++;
    if ({spi_cyc_o, spi_stb_o, spi_we_o, spi_adr_o, spi_dat_o, spi_cs_o, cmd_ready_o, wr_ready_o,
         rd_valid_o, rd_data_o, busy_o, done_o, err_o} !== 28'd0) begin
      errors++; $display("FAIL reset_outputs: some output nonzero during reset, required all 0");
    end
    #11 rst_n = 1'b1;
    n = 0;
    while (n < 100 && !cmd_ready_o) begin @(negedge clk); n++; end
    #1;
    checks++;
    if (spcr_log.size() != 1 || acc_cnt != 1) begin
      errors++; $display("FAIL init_writes: spcr=%0d total=%0d required 1 and 1", spcr_log.size(), acc_cnt);
    end
    checks++;
    if (spcr_log.size() > 0 && spcr_log[0] !== 8'h50) begin
      errors++; $display("FAIL init_spcr: got %h required 50", spcr_log[0]);
    end
    checks++;
    if (cs_hi_cnt != 0 || !cmd_ready_o) begin
      errors++; $display("FAIL init_cs: cs_hi=%0d ready=%0b required 0 and 1", cs_hi_cnt, cmd_ready_o);
    end
  endtask

  task automatic test_read_id;
    logic [7:0] ex_tx[4] = '{8'h9F, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] ex_rd[3] = '{8'hEF, 8'h40, 8'h18};
    int lat, d0, v0, bad;
    tx_log.delete(); rd_log.delete(); miso_q.delete();
    miso_q = '{8'h00, 8'hEF, 8'h40, 8'h18};
    d0 = done_cnt; v0 = cs_viol;
    send_cmd(8'h9F, 24'h0, 1'b0, 1'b0, 16'd3);
    wait_done("read_id", 500, lat);
    bad = (tx_log.size() != 4);
    for (int i = 0; i < 4 && !bad; i++) if (tx_log[i] !== ex_tx[i]) bad = 1;
    checks++;
    if (bad) begin errors++; $display("FAIL read_id_tx: %0d bytes %p required 9F FF FF FF", tx_log.size(), tx_log); end
    bad = (rd_log.size() != 3);
    for (int i = 0; i < 3 && !bad; i++) if (rd_log[i] !== ex_rd[i]) bad = 1;
    checks++;
    if (bad) begin errors++; $display("FAIL read_id_rd: %p required EF 40 18", rd_log); end
    checks++;
    if (cs_viol != v0) begin errors++; $display("FAIL read_id_cs: %0d accesses with cs low, required 0", cs_viol - v0); end
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL read_id_done_cnt: %0d required 1", done_cnt - d0); end
  endtask

  task automatic test_read_stall;
    logic [7:0] ex_tx[6] = '{8'h03, 8'h12, 8'h34, 8'h56, 8'hFF, 8'hFF};
    int lat, n, c0, vcnt, bad;
    tx_log.delete(); rd_log.delete(); miso_q.delete();
    miso_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hA1, 8'hB2};
    poll_delay = 1;
    rd_ready = 1'b0;
    send_cmd(8'h03, 24'h123456, 1'b1, 1'b0, 16'd2);
    n = 0;
    while (n < 500 && !rd_valid_o) begin @(negedge clk); n++; end
    #1;
    c0 = cyc_cnt; vcnt = 0;
    repeat (10) begin @(negedge clk); if (rd_valid_o) vcnt++; end
    #1;
    checks++;
    if (cyc_cnt != c0 || vcnt != 10) begin
      errors++; $display("FAIL stall_quiet: cyc cycles=%0d valid cycles=%0d required 0 and 10", cyc_cnt - c0, vcnt);
    end
    @(posedge clk); #1 rd_ready = 1'b1;
    wait_done("read_stall", 500, lat);
    bad = (tx_log.size() != 6);
    for (int i = 0; i < 6 && !bad; i++) if (tx_log[i] !== ex_tx[i]) bad = 1;
    checks++;
    if (bad) begin errors++; $display("FAIL stall_tx: %p required 03 12 34 56 FF FF", tx_log); end
    checks++;
    if (rd_log.size() != 2 || rd_log[0] !== 8'hA1 || rd_log[1] !== 8'hB2) begin
      errors++; $display("FAIL stall_rd: %p required A1 B2", rd_log);
    end
    poll_delay = 0;
  endtask

  task automatic feed4;
    logic [7:0] d[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int gap[4] = '{2, 0, 3, 1};
    int n;
    for (int i = 0; i < 4; i++) begin
      repeat (gap[i]) begin @(posedge clk); #1; end
      wr_data = d[i]; wr_valid = 1'b1;
      n = 0;
      while (n < 300) begin @(negedge clk); if (wr_ready_o) break; n++; end
      @(posedge clk); #1;
      wr_valid = 1'b0;
    end
  endtask

  task automatic test_page_program;
    logic [7:0] ex_tx[8] = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    int lat, w0, bad, ex_sz;
`ifdef TISC_SPI_WIP_POLL_EN
    ex_sz = 10;
`else
    ex_sz = 8;
`endif
    tx_log.delete(); miso_q.delete();
    w0 = wr_cnt;
    send_cmd(8'h02, 24'h000100, 1'b1, 1'b1, 16'd4);
    fork
      feed4();
      wait_done("page_program", 1000, lat);
    join
    bad = (tx_log.size() < 8);
    for (int i = 0; i < 8 && !bad; i++) if (tx_log[i] !== ex_tx[i]) bad = 1;
    checks++;
    if (bad) begin errors++; $display("FAIL pp_tx: %p required 02 00 01 00 11 22 33 44", tx_log); end
    checks++;
    if (tx_log.size() != ex_sz) begin errors++; $display("FAIL pp_tx_count: %0d required %0d", tx_log.size(), ex_sz); end
    checks++;
    if (wr_cnt - w0 != 4) begin errors++; $display("FAIL pp_wr_ready: %0d pulses required 4", wr_cnt - w0); end
  endtask

  task automatic test_timeout;
    int lat, d0;
    miso_q.delete();
    blk_spdr = 1'b1;
    d0 = done_cnt;
    send_cmd(8'h9F, 24'h0, 1'b0, 1'b0, 16'd1);
    wait_done("timeout", 2000, lat);
    checks++;
    if (last_run != 256) begin errors++; $display("FAIL tmo_cyc_len: cyc held %0d cycles required 256", last_run); end
    checks++;
    if (err_o !== 1'b1 || spi_cs_o !== 1'b0) begin
      errors++; $display("FAIL tmo_flags: err=%0b cs=%0b required 1 and 0", err_o, spi_cs_o);
    end
    @(negedge clk); #1;
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL tmo_done: %0d pulses required 1", done_cnt - d0); end
    blk_spdr = 1'b0;
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("FAIL tmo_sticky: err=%0b required 1", err_o); end
    send_cmd(8'h05, 24'h0, 1'b0, 1'b0, 16'd0);
    checks++;
    if (err_o !== 1'b0) begin errors++; $display("FAIL tmo_err_clear: err=%0b required 0", err_o); end
    wait_done("opcode_only", 200, lat);
    checks++;
    if (lat != 9) begin errors++; $display("FAIL opcode_only_latency: %0d cycles required 9", lat); end
  endtask

  task automatic test_reset_mid;
    int n, s0;
    tx_log.delete(); miso_q.delete();
    miso_q = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_cmd(8'h03, 24'h0, 1'b0, 1'b0, 16'd8);
    n = 0;
    while (n < 500 && tx_log.size() < 3) begin @(negedge clk); n++; end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({spi_cyc_o, spi_stb_o, spi_we_o, spi_adr_o, spi_dat_o, spi_cs_o, cmd_ready_o, wr_ready_o,
         rd_valid_o, rd_data_o, busy_o, done_o, err_o} !== 28'd0) begin
      errors++; $display("FAIL midreset_outputs: cs=%0b cyc=%0b rd_data=%h busy=%0b required all 0",
                         spi_cs_o, spi_cyc_o, rd_data_o, busy_o);
    end
    s0 = spcr_log.size();
    #20 rst_n = 1'b1;
    miso_q.delete();
    n = 0;
    while (n < 100 && !cmd_ready_o) begin @(negedge clk); n++; end
    #1;
    checks++;
    if (spcr_log.size() != s0 + 1 || spcr_log[spcr_log.size()-1] !== 8'h50) begin
      errors++; $display("FAIL midreset_init: %0d new SPCR writes required 1 of 50", spcr_log.size() - s0);
    end
  endtask

`ifdef TISC_SPI_WIP_POLL_EN
  task automatic test_wip;
    int lat, d0, nrdsr;
    tx_log.delete(); miso_q.delete();
    miso_q = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00};
    d0 = done_cnt;
    wr_data = 8'hA5; wr_valid = 1'b1;
    send_cmd(8'h02, 24'h0, 1'b0, 1'b1, 16'd1);
    wait_done("wip", 1000, lat);
    wr_valid = 1'b0;
    nrdsr = 0;
    for (int i = 2; i < tx_log.size(); i += 2) if (tx_log[i] === 8'h05) nrdsr++;
    checks++;
    if (nrdsr != 3 || tx_log.size() != 8) begin
      errors++; $display("FAIL wip_frames: %0d RDSR, %0d bytes required 3 and 8", nrdsr, tx_log.size());
    end
    @(negedge clk); #1;
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL wip_done: %0d pulses required 1", done_cnt - d0); end
  endtask
`endif

  initial begin
    test_reset();
    test_read_id();
    test_read_stall();
    test_page_program();
    test_timeout();
    test_reset_mid();
`ifdef TISC_SPI_WIP_POLL_EN
    test_wip();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
